// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory controller: the 5-bit opcode
// set, the general-register codes, the controller state encoding and a few
// small helpers for picking apart 16-bit instruction words.
package instr_mem_pkg;

    localparam int OPCODE_W = 5;
    localparam int REG_W    = 3;

    // Opcode constants; NOP is all-zero so an all-zero fill word is a NOP.
    localparam logic [OPCODE_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_STORE = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_SUBI  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_ADD   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SUB   = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_AND   = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_OR    = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_XOR   = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_SHL   = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_SHR   = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_CMP   = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_BZ    = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_BNZ   = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_JUMP  = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_CALL  = 5'b10001;
    localparam logic [OPCODE_W-1:0] OP_RET   = 5'b10010;

    // General-register codes.
    localparam logic [REG_W-1:0] GR0 = 3'd0;
    localparam logic [REG_W-1:0] GR1 = 3'd1;
    localparam logic [REG_W-1:0] GR2 = 3'd2;
    localparam logic [REG_W-1:0] GR3 = 3'd3;
    localparam logic [REG_W-1:0] GR4 = 3'd4;
    localparam logic [REG_W-1:0] GR5 = 3'd5;
    localparam logic [REG_W-1:0] GR6 = 3'd6;
    localparam logic [REG_W-1:0] GR7 = 3'd7;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Field layout of a 16-bit instruction word.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [7:0]          imm;
    } instr_fields_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [15:0] word);
        instr_fields_t f;
        f = word;
        return f.opcode;
    endfunction

    function automatic logic is_nop(input logic [15:0] word);
        return opcode_of(word) == OP_NOP;
    endfunction

endpackage

// File: rtl/instr_ram.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Contents are never cleared; the read register only updates on rd_en so the
// last read word stays on rd_data while the reader is stalled.
module instr_ram
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; holds the previous word when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: streams a program into instr_ram at address 0
// upward, then serves single-cycle-latency fetches. Words at or beyond the
// loaded count read back as FILL_INSTR, so stale contents from earlier loads
// are never visible. A stalled fetch holds its outputs.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter logic [DATA_W-1:0] FILL_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              load_end;
    logic              rd_en;
    logic              in_range;
    logic              sel_ram_p1;
    logic [DATA_W-1:0] ram_rd_data;

    // A word is written only in LOAD, and never in a cycle that restarts the
    // load or resets the block.
    assign wr_en    = (state == ST_LOAD) && load_valid && !load_start && !rst;
    assign load_end = wr_en && (load_last || (wr_ptr == LAST_ADDR));

    // Only fetches that will actually be answered touch the read port, so the
    // RAM output register doubles as the held fetch word.
    assign rd_en    = (state == ST_RUN) && fetch_req && !fetch_stall && !load_start && !rst;
    assign in_range = ({1'b0, fetch_addr} < load_count);

    assign load_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD);

    // Final output mux: the RAM word when the registered fetch hit loaded
    // memory, otherwise the fill word.
    assign fetch_instr = sel_ram_p1 ? ram_rd_data : FILL_INSTR;

    instr_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (fetch_addr),
        .rd_data (ram_rd_data)
    );

    // Load FSM: pointer, count and the one-cycle completion pulse. The pointer
    // is left on the last address at completion rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            load_count <= '0;
            load_done  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state      <= ST_LOAD;
                wr_ptr     <= '0;
                load_count <= '0;
            end else if (wr_en) begin
                load_count <= load_count + 1'b1;
                if (load_end) begin
                    state     <= ST_RUN;
                    load_done <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // Fetch response stage: valid flag and RAM/fill select, with stall hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            sel_ram_p1  <= 1'b0;
        end else if (load_start || (state != ST_RUN)) begin
            fetch_valid <= 1'b0;
            sel_ram_p1  <= 1'b0;
        end else if (fetch_stall) begin
            fetch_valid <= fetch_valid;
            sel_ram_p1  <= sel_ram_p1;
        end else if (fetch_req) begin
            fetch_valid <= 1'b1;
            sel_ram_p1  <= in_range;
        end else begin
            fetch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl. A behavioural model of the load/fetch
// rules predicts every cycle's control outputs and every fetch response; a
// negedge monitor pops and compares. A second, 2-bit-address instance checks
// automatic completion when the memory fills.
module tb_instr_mem_ctrl;

    localparam logic [15:0] FILL = 16'h0000;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic        clk;
    logic        rst, load_start, load_valid, load_last, fetch_req, fetch_stall;
    logic [15:0] load_data;
    logic [7:0]  fetch_addr;
    logic        load_ready, load_done, fetch_valid, busy;
    logic [8:0]  load_count;
    logic [15:0] fetch_instr;

    logic        rst2, load_start2, load_valid2, load_last2, fetch_req2, fetch_stall2;
    logic [15:0] load_data2;
    logic [1:0]  fetch_addr2;
    logic        load_ready2, load_done2, fetch_valid2, busy2;
    logic [2:0]  load_count2;
    logic [15:0] fetch_instr2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [15:0] instr;
    } fetch_exp_t;

    typedef struct {
        int          due;
        logic        busy;
        logic        done;
        int          count;
        logic        fv;
        logic        fi_chk;
        logic [15:0] fi;
    } ctrl_exp_t;

    fetch_exp_t fq[$];
    ctrl_exp_t  cq[$];

    // Reference model state
    logic [15:0] ref_mem [256];
    int          ref_count = 0;
    int          ref_ptr   = 0;
    int          mode      = M_IDLE;
    logic        ref_valid = 1'b0;
    logic [15:0] ref_instr = FILL;

    instr_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .FILL_INSTR(16'h0000)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .load_done(load_done), .load_count(load_count), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_stall(fetch_stall), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .busy(busy)
    );

    instr_mem_ctrl #(.DATA_W(16), .ADDR_W(2), .FILL_INSTR(16'h0000)) dut2 (
        .clk(clk), .rst(rst2), .load_start(load_start2), .load_valid(load_valid2),
        .load_data(load_data2), .load_last(load_last2), .load_ready(load_ready2),
        .load_done(load_done2), .load_count(load_count2), .fetch_req(fetch_req2),
        .fetch_addr(fetch_addr2), .fetch_stall(fetch_stall2), .fetch_valid(fetch_valid2),
        .fetch_instr(fetch_instr2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One stimulus cycle: apply inputs just after the edge and advance the
    // model by the rules that govern how those inputs are sampled.
    task automatic drive(input logic r, input logic st, input logic lv, input logic [15:0] ld,
                         input logic ll, input logic fr, input logic [7:0] fa, input logic fs);
        logic done;
        logic fi_chk;
        @(posedge clk);
        #1;
        rst = r; load_start = st; load_valid = lv; load_data = ld; load_last = ll;
        fetch_req = fr; fetch_addr = fa; fetch_stall = fs;
        done   = 1'b0;
        fi_chk = 1'b1;
        if (r) begin
            mode = M_IDLE; ref_count = 0; ref_ptr = 0; ref_valid = 1'b0; ref_instr = FILL;
        end else begin
            if (st && mode == M_RUN) fi_chk = 1'b0;
            if (mode != M_RUN || st) begin
                ref_valid = 1'b0;
                ref_instr = FILL;
            end else if (fs) begin
                ref_valid = ref_valid;
            end else if (fr) begin
                ref_valid = 1'b1;
                ref_instr = (int'(fa) < ref_count) ? ref_mem[fa] : FILL;
            end else begin
                ref_valid = 1'b0;
            end
            if (st) begin
                mode = M_LOAD; ref_count = 0; ref_ptr = 0;
            end else if (mode == M_LOAD && lv) begin
                ref_mem[ref_ptr] = ld;
                ref_ptr++;
                ref_count++;
                if (ll || ref_count == 256) begin
                    mode = M_RUN;
                    done = 1'b1;
                end
            end
        end
        if (ref_valid) fq.push_back('{cyc + 1, ref_instr});
        cq.push_back('{cyc + 1, (mode == M_LOAD), done, ref_count, ref_valid, fi_chk, ref_instr});
    endtask

    task automatic idle();
        drive(0, 0, 0, 16'h0, 0, 0, 8'h0, 0);
    endtask

    task automatic word(input logic [15:0] d, input logic last);
        drive(0, 0, 1, d, last, 0, 8'h0, 0);
    endtask

    task automatic fetch(input logic [7:0] a, input logic stall);
        drive(0, 0, 0, 16'h0, 0, 1, a, stall);
    endtask

    // Monitor: per-cycle control expectations plus fetch scoreboard.
    always @(negedge clk) begin
        ctrl_exp_t  c;
        fetch_exp_t f;
        if (cq.size() > 0 && cq[0].due == cyc) begin
            c = cq.pop_front();
            chk("busy",        {31'b0, busy},        {31'b0, c.busy});
            chk("load_ready",  {31'b0, load_ready},  {31'b0, c.busy});
            chk("load_done",   {31'b0, load_done},   {31'b0, c.done});
            chk("load_count",  {23'b0, load_count},  c.count);
            chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, c.fv});
            if (c.fi_chk) chk("fetch_instr_state", {16'b0, fetch_instr}, {16'b0, c.fi});
        end
        if (fetch_valid === 1'b1) begin
            if (fq.size() == 0) begin
                chk("unexpected_fetch_valid", 32'd1, 32'd0);
            end else begin
                f = fq.pop_front();
                chk("fetch_due_cycle", cyc, f.due);
                chk("fetch_instr", {16'b0, fetch_instr}, {16'b0, f.instr});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0; load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
        fetch_req = 0; fetch_addr = 0; fetch_stall = 0;
        rst2 = 0; load_start2 = 0; load_valid2 = 0; load_data2 = 0; load_last2 = 0;
        fetch_req2 = 0; fetch_addr2 = 0; fetch_stall2 = 0;

        // Reset, then fetches in IDLE are ignored
        drive(1, 0, 0, 16'h0, 0, 0, 8'h0, 0);
        drive(1, 1, 1, 16'hFFFF, 1, 1, 8'h0, 0);
        fetch(8'd0, 0);
        fetch(8'd0, 0);

        // Three-word program, fetch on the completion cycle, out-of-range fetch
        drive(0, 1, 0, 16'h0, 0, 0, 8'h0, 0);
        word(16'h4805, 0);
        word(16'hD007, 0);
        word(16'h0800, 1);
        fetch(8'd1, 0);
        fetch(8'd5, 0);
        idle();

        // Stall holds the response while the address moves
        fetch(8'd0, 0);
        fetch(8'd2, 1);
        fetch(8'd1, 1);
        fetch(8'd3, 1);
        fetch(8'd2, 0);
        idle();

        // Restart from RUN mid-fetch, restart again mid-load
        fetch(8'd0, 0);
        drive(0, 1, 0, 16'h0, 0, 1, 8'h0, 0);
        word(16'hAAAA, 0);
        word(16'hBBBB, 0);
        drive(0, 1, 1, 16'hBEEF, 0, 0, 8'h0, 0);
        word(16'h1234, 1);
        fetch(8'd1, 0);
        fetch(8'd0, 0);
        idle();

        // Reset while busy abandons the load
        drive(0, 1, 0, 16'h0, 0, 0, 8'h0, 0);
        word(16'h5555, 0);
        drive(1, 0, 1, 16'h6666, 0, 0, 8'h0, 0);
        idle();
        fetch(8'd0, 0);

        // Randomized loads and fetch traffic
        for (int r = 0; r < 8; r++) begin
            int n;
            drive(0, 1, 0, 16'h0, 0, 0, 8'h0, 0);
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) idle();
                word(16'($urandom), (k == n - 1));
            end
            for (int k = 0; k < 30; k++) begin
                logic        st, lv, fr, fs;
                logic [7:0]  fa;
                st = ($urandom_range(0, 49) == 0);
                lv = ($urandom_range(0, 3) == 0);
                fr = ($urandom_range(0, 2) != 0);
                fs = ($urandom_range(0, 3) == 0);
                fa = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                drive(0, st, lv, 16'($urandom), 1'($urandom), fr, fa, fs);
            end
        end

        // Drain
        idle();
        idle();
        idle();
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("fetch_queue_empty", fq.size(), 0);
        chk("ctrl_queue_empty",  cq.size(), 0);

        // Small instance: memory fills without load_last
        @(posedge clk); #1;
        rst2 = 1;
        @(posedge clk); #1;
        rst2 = 0; load_start2 = 1;
        chk("d2_reset_count", {29'b0, load_count2}, 0);
        chk("d2_reset_busy",  {31'b0, busy2}, 0);
        @(posedge clk); #1;
        load_start2 = 0;
        chk("d2_ready_in_load", {31'b0, load_ready2}, 1);
        for (int i = 0; i < 4; i++) begin
            load_valid2 = 1; load_data2 = 16'h1000 + 16'(i); load_last2 = 0;
            @(posedge clk); #1;
        end
        load_valid2 = 0; fetch_req2 = 1; fetch_addr2 = 2'd3;
        chk("d2_done_pulse",  {31'b0, load_done2}, 1);
        chk("d2_count_full",  {29'b0, load_count2}, 4);
        chk("d2_ready_after", {31'b0, load_ready2}, 0);
        chk("d2_busy_after",  {31'b0, busy2}, 0);
        @(posedge clk); #1;
        fetch_req2 = 0;
        chk("d2_done_single", {31'b0, load_done2}, 0);
        chk("d2_fetch_valid", {31'b0, fetch_valid2}, 1);
        chk("d2_fetch_instr", {16'b0, fetch_instr2}, 32'h1003);
        chk("d2_count_hold",  {29'b0, load_count2}, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
